// File: rtl/ovf_mon_pkg.sv
// Shared widths, the wrap-record type and small helpers for the overflow event monitor.
package ovf_mon_pkg;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_DEPTH = 4;
    localparam int EPOCH_W   = 8;
    localparam int GAP_W     = 8;
    localparam int DROP_W    = 4;

    localparam logic [DROP_W-1:0] DROP_SAT = 4'd15;

    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [GAP_W-1:0]   gap;
    } ovf_evt_t;

    function automatic logic [GAP_W-1:0] satIncGap(input logic [GAP_W-1:0] value);
        return (value == '1) ? value : value + GAP_W'(1);
    endfunction

endpackage

// File: rtl/ovf_event_fifo.sv
// Small synchronous FIFO of wrap records; the head is read directly from storage.
module ovf_event_fifo
    import ovf_mon_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push_i,
    input  ovf_evt_t data_i,
    output logic     full_o,
    input  logic     pop_i,
    output logic     empty_o,
    output ovf_evt_t head_o
);

    localparam int AW = $clog2(DEPTH);

    ovf_evt_t       mem_q [DEPTH];
    logic [AW:0]    wrPtr_q, wrPtr_d;
    logic [AW:0]    rdPtr_q, rdPtr_d;
    logic           doPush;
    logic           doPop;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    always_comb begin
        empty_o = (wrPtr_q == rdPtr_q);
        full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
        doPop   = pop_i && !empty_o;
        doPush  = push_i && (!full_o || doPop);
        wrPtr_d = doPush ? wrPtr_q + (AW+1)'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + (AW+1)'(1) : rdPtr_q;
        head_o  = mem_q[rdPtr_q[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/overflow_event_monitor.sv
// Detects F->0 wraps of the upstream counter, numbers them, measures the gap
// between wraps and streams {epoch, gap} records out through a small FIFO.
module overflow_event_monitor
    import ovf_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CNT_W-1:0]   count,
    input  logic               overflow,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [EPOCH_W-1:0] evt_epoch,
    output logic [GAP_W-1:0]   evt_gap,
    output logic [EPOCH_W-1:0] epoch,
    output logic               first_ovf,
    output logic               dropped,
    output logic [DROP_W-1:0]  drop_count
);

    logic [CNT_W-1:0]   prevCount_q;
    logic               prevVld_q;
    logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               firstOvf_q, firstOvf_d;
    logic               dropped_q, dropped_d;
    logic [DROP_W-1:0]  dropCount_q, dropCount_d;

    logic               wrap;
    logic               pop;
    logic               fifoPush;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               dropEvt;
    ovf_evt_t           newEvt;
    ovf_evt_t           headEvt;

    // A wrap is only trusted once a previous sample exists, so a count that
    // straddles reset release never produces a record.
    always_comb begin
        wrap         = prevVld_q && (prevCount_q == '1) && (count == '0);
        pop          = !fifoEmpty && evt_ready;
        fifoPush     = wrap && (!fifoFull || pop);
        dropEvt      = wrap && fifoFull && !pop;
        newEvt.epoch = epoch_q;
        newEvt.gap   = satIncGap(gapCnt_q);
        gapCnt_d     = wrap ? '0 : satIncGap(gapCnt_q);
        epoch_d      = wrap ? epoch_q + EPOCH_W'(1) : epoch_q;
        firstOvf_d   = firstOvf_q | overflow;
        dropped_d    = dropped_q | dropEvt;
        dropCount_d  = dropCount_q;
        if (dropEvt && (dropCount_q != DROP_SAT)) begin
            dropCount_d = dropCount_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prevCount_q <= '0;
            prevVld_q   <= 1'b0;
            gapCnt_q    <= '0;
            epoch_q     <= '0;
            firstOvf_q  <= 1'b0;
            dropped_q   <= 1'b0;
            dropCount_q <= '0;
        end else begin
            prevCount_q <= count;
            prevVld_q   <= 1'b1;
            gapCnt_q    <= gapCnt_d;
            epoch_q     <= epoch_d;
            firstOvf_q  <= firstOvf_d;
            dropped_q   <= dropped_d;
            dropCount_q <= dropCount_d;
        end
    end

    ovf_event_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifoPush),
        .data_i  (newEvt),
        .full_o  (fifoFull),
        .pop_i   (pop),
        .empty_o (fifoEmpty),
        .head_o  (headEvt)
    );

    always_comb begin
        evt_valid  = !fifoEmpty;
        evt_epoch  = headEvt.epoch;
        evt_gap    = headEvt.gap;
        epoch      = epoch_q;
        first_ovf  = firstOvf_q;
        dropped    = dropped_q;
        drop_count = dropCount_q;
    end

endmodule

// File: tb/tb_overflow_event_monitor.sv
// Directed bench for overflow_event_monitor with hand-computed expected values.
module tb_overflow_event_monitor;

    logic       clock;
    logic       reset;
    logic [3:0] count;
    logic       overflow;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_epoch;
    logic [7:0] evt_gap;
    logic [7:0] epoch;
    logic       first_ovf;
    logic       dropped;
    logic [3:0] drop_count;

    int checks = 0;
    int errors = 0;

    overflow_event_monitor dut (
        .clock      (clock),
        .reset      (reset),
        .count      (count),
        .overflow   (overflow),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_epoch  (evt_epoch),
        .evt_gap    (evt_gap),
        .epoch      (epoch),
        .first_ovf  (first_ovf),
        .dropped    (dropped),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] value);
        count = value;
        tick();
    endtask

    task automatic doReset();
        reset = 1'b1;
        count = 4'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic doWrap();
        applyStimulus(4'hF);
        applyStimulus(4'h0);
    endtask

    initial begin
        reset     = 1'b1;
        count     = 4'd0;
        overflow  = 1'b0;
        evt_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_valid", evt_valid, 0);
        checkOutput("rst_epoch", epoch, 0);
        checkOutput("rst_evt_epoch", evt_epoch, 0);
        checkOutput("rst_evt_gap", evt_gap, 0);
        checkOutput("rst_dropped", dropped, 0);
        checkOutput("rst_drop_count", drop_count, 0);
        checkOutput("rst_first_ovf", first_ovf, 0);

        // Counter advanced on the reset-release edge: first visible value is 1.
        reset = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            applyStimulus(4'(k));
            if (k == 16) begin
                checkOutput("run_valid0", evt_valid, 1);
                checkOutput("run_epoch0", evt_epoch, 0);
                checkOutput("run_gap0", evt_gap, 16);
            end
            if (k == 15 || k == 17) checkOutput("run_pulse_lo", evt_valid, 0);
            if (k == 32) begin
                checkOutput("run_valid1", evt_valid, 1);
                checkOutput("run_epoch1", evt_epoch, 1);
                checkOutput("run_gap1", evt_gap, 16);
            end
        end
        checkOutput("run_epoch_cnt", epoch, 2);
        checkOutput("run_pulse_lo2", evt_valid, 0);

        // Back-pressure: six wraps into a four-entry FIFO.
        doReset();
        evt_ready = 1'b0;
        for (int w = 0; w < 6; w++) doWrap();
        checkOutput("full_dropped", dropped, 1);
        checkOutput("full_drop_count", drop_count, 2);
        checkOutput("full_epoch", epoch, 6);
        applyStimulus(4'd5);
        checkOutput("hold_evt_epoch", evt_epoch, 0);
        checkOutput("hold_evt_gap", evt_gap, 2);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", evt_valid, 1);
            checkOutput("drain_epoch", evt_epoch, 32'(i));
            applyStimulus(4'd5);
        end
        checkOutput("drain_empty", evt_valid, 0);

        // Full FIFO, wrap coincident with a pop: push must be accepted.
        evt_ready = 1'b0;
        for (int w = 0; w < 4; w++) doWrap();
        checkOutput("fp_drop_before", drop_count, 2);
        applyStimulus(4'hF);
        evt_ready = 1'b1;
        applyStimulus(4'h0);
        checkOutput("fp_drop_count", drop_count, 2);
        checkOutput("fp_epoch", epoch, 11);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fp_valid", evt_valid, 1);
            checkOutput("fp_order", evt_epoch, 32'(7 + i));
            applyStimulus(4'h0);
        end
        checkOutput("fp_empty", evt_valid, 0);

        // Slow counter: gap saturates.
        doReset();
        evt_ready = 1'b1;
        for (int v = 1; v < 16; v++) begin
            for (int j = 0; j < 20; j++) applyStimulus(4'(v));
        end
        applyStimulus(4'h0);
        checkOutput("sat_valid", evt_valid, 1);
        checkOutput("sat_gap", evt_gap, 255);
        checkOutput("sat_epoch", evt_epoch, 0);
        applyStimulus(4'h0);

        // Non-wrap jumps and a count of F at reset release.
        reset = 1'b1;
        count = 4'hF;
        tick();
        reset = 1'b0;
        applyStimulus(4'h0);
        checkOutput("nw_release", epoch, 0);
        applyStimulus(4'hF);
        applyStimulus(4'h3);
        applyStimulus(4'h0);
        checkOutput("nw_f30", epoch, 0);
        applyStimulus(4'h7);
        applyStimulus(4'h0);
        checkOutput("nw_70", epoch, 0);
        checkOutput("nw_valid", evt_valid, 0);
        doWrap();
        checkOutput("nw_real_wrap", epoch, 1);
        applyStimulus(4'h0);

        // Reset with queued records, then first_ovf behaviour.
        doReset();
        evt_ready = 1'b0;
        for (int w = 0; w < 3; w++) doWrap();
        overflow = 1'b1;
        applyStimulus(4'hF);
        overflow = 1'b0;
        checkOutput("pre_first_ovf", first_ovf, 1);
        checkOutput("pre_valid", evt_valid, 1);
        reset = 1'b1;
        count = 4'h0;
        tick();
        reset = 1'b0;
        checkOutput("mr_valid", evt_valid, 0);
        checkOutput("mr_epoch", epoch, 0);
        checkOutput("mr_dropped", dropped, 0);
        checkOutput("mr_first_ovf", first_ovf, 0);
        applyStimulus(4'h0);
        checkOutput("mr_span_wrap", epoch, 0);
        overflow = 1'b1;
        checkOutput("ovf_not_yet", first_ovf, 0);
        tick();
        overflow = 1'b0;
        checkOutput("ovf_set", first_ovf, 1);
        tick();
        checkOutput("ovf_sticky", first_ovf, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
